// File: rtl/tx_fifo.sv
// rtl/tx_fifo.sv - frame-aware transmit buffer with rewind-on-retry for the MAC transmit path
// Optional: TX_FIFO_DROP_ON_OVERFLOW_EN drops the whole open frame when a write hits a full buffer.
module tx_fifo #(
  parameter int ADDR_WIDTH  = 11,
  parameter int COUNT_WIDTH = 12
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       data_in_write,
  input  logic       data_in_start,
  input  logic       data_in_end,
  output logic       data_in_full,
  output logic       data_in_overflow,
  output logic [7:0] fifo_data,
  output logic       fifo_data_start,
  output logic       fifo_data_end,
  input  logic       fifo_data_read,
  output logic [6:0] fifo_count,
  input  logic       fifo_retry
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [9:0]             mem [DEPTH];
  logic [PW-1:0]          wr_ptr, wr_frame_ptr, rd_ptr, commit_ptr;
  logic [PW-1:0]          wr_addr, used;
  logic [COUNT_WIDTH-1:0] frame_cnt;
  logic                   wr_accept, wr_refuse, rd_empty, rd_consume, frame_inc;

  // Space is released only at commit so a retry can always replay the whole frame.
  assign used         = wr_ptr - commit_ptr;
  assign data_in_full = (used == PW'(DEPTH));
  assign rd_empty     = (rd_ptr == wr_frame_ptr);
  // A start byte always lands at the frame base, which discards any open partial frame.
  assign wr_addr      = data_in_start ? wr_frame_ptr : wr_ptr;

`ifdef TX_FIFO_DROP_ON_OVERFLOW_EN
  logic dropping;

  assign wr_accept = data_in_write && !data_in_full && !dropping;
  assign wr_refuse = data_in_write && data_in_full && !dropping;

  always_ff @(posedge clock) begin
    if (reset) begin
      dropping <= 1'b0;
    end else if (wr_refuse) begin
      dropping <= !data_in_end;
    end else if (dropping && data_in_write && data_in_end) begin
      dropping <= 1'b0;
    end
  end
`else
  assign wr_accept = data_in_write && !data_in_full;
  assign wr_refuse = data_in_write && data_in_full;
`endif

  assign frame_inc  = wr_accept && data_in_end;
  assign rd_consume = !fifo_retry && fifo_data_read && fifo_data_end;

  always_ff @(posedge clock) begin
    if (wr_accept) begin
      mem[wr_addr[ADDR_WIDTH-1:0]] <= {data_in_end, data_in_start, data_in};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr           <= '0;
      wr_frame_ptr     <= '0;
      data_in_overflow <= 1'b0;
    end else begin
      data_in_overflow <= wr_refuse;
      if (wr_accept) begin
        wr_ptr <= wr_addr + PW'(1);
        if (data_in_end) begin
          wr_frame_ptr <= wr_addr + PW'(1);
        end
      end
`ifdef TX_FIFO_DROP_ON_OVERFLOW_EN
      else if (wr_refuse) begin
        wr_ptr <= wr_frame_ptr;
      end
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr          <= '0;
      commit_ptr      <= '0;
      fifo_data       <= '0;
      fifo_data_start <= 1'b0;
      fifo_data_end   <= 1'b0;
    end else if (fifo_retry) begin
      rd_ptr          <= commit_ptr;
      fifo_data       <= '0;
      fifo_data_start <= 1'b0;
      fifo_data_end   <= 1'b0;
    end else if (fifo_data_read) begin
      if (fifo_data_end) begin
        // The read after the last byte commits the frame; rd_ptr already sits on the next one.
        commit_ptr      <= rd_ptr;
        fifo_data       <= '0;
        fifo_data_start <= 1'b0;
        fifo_data_end   <= 1'b0;
      end else if (!rd_empty) begin
        {fifo_data_end, fifo_data_start, fifo_data} <= mem[rd_ptr[ADDR_WIDTH-1:0]];
        rd_ptr <= rd_ptr + PW'(1);
      end else begin
        fifo_data       <= '0;
        fifo_data_start <= 1'b0;
        fifo_data_end   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (frame_inc && !rd_consume) begin
      frame_cnt <= frame_cnt + COUNT_WIDTH'(1);
    end else if (rd_consume && !frame_inc) begin
      frame_cnt <= frame_cnt - COUNT_WIDTH'(1);
    end
  end

  assign fifo_count = (frame_cnt > COUNT_WIDTH'(127)) ? 7'd127 : frame_cnt[6:0];

endmodule
